uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side buffer directly downstream of the UART receiver.
//  - Captures each received byte (rx_data qualified by rx_done) into a circular FIFO.
//  - Presents bytes to the host over a valid/ready interface; flags overflow; reports fill level.
//  - Decouples the bursty serial receive path from a slower or stalling consumer.
// PARAMETERS
//  DBITS   8    data width; must match the receiver's dbits
//  DEPTH   16   FIFO entries; power of two, >=2
//  AW      4    address width = log2(DEPTH)
//  TO_TICKS 64  oversampling ticks of line silence before timeout (only with UART_RX_FIFO_TIMEOUT_EN)
// PORTS
//  clk       in   1         system clock, rising edge
//  rst       in   1         asynchronous, active-low reset
//  tick      in   1         baud oversample tick, same as the receiver's (used by timeout only)
//  rx_done   in   1         receiver frame-complete indication; may stay high >1 cycle
//  rx_data   in   DBITS     received byte; stable while rx_done high
//  m_valid   out  1         head entry available
//  m_data    out  DBITS     head entry (first-word fall-through)
//  m_ready   in   1         consumer accepts head when m_valid&m_ready
//  count     out  AW+1      entries held, 0..DEPTH
//  full      out  1         count==DEPTH
//  overflow  out  1         sticky: a byte arrived while full
//  ovf_clr   in   1         synchronous clear of overflow
//  rx_timeout out 1         see CONFIGURATION; tied 0 when feature absent
// BEHAVIOUR
//  Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, m_valid=0, full=0, overflow=0,
//   rx_timeout=0, edge-detect register=0. m_data undefined (mem not reset).
//  Capture: push = rx_done & ~rx_done_q (rising edge, registered q); one byte per frame
//   regardless of how long rx_done stays high.
//  Write: on push & ~full -> mem[wr_ptr]<=rx_data, wr_ptr+1 (wraps mod DEPTH).
//   On push & full -> byte dropped, overflow<=1; pointers unchanged.
//  Read: pop = m_valid & m_ready -> rd_ptr+1 (wraps). m_data = mem[rd_ptr], combinational FWFT.
//  Latency: byte written at edge N is visible on m_data/m_valid after edge N (next cycle).
//  count: +1 on write-only, -1 on pop-only, unchanged on simultaneous write+pop
//   (including at full: the pop frees a slot, so the push is accepted, no overflow).
//  Simultaneous push & pop when empty: write occurs, pop impossible (m_valid=0); count->1.
//  m_valid = (count!=0); full = (count==DEPTH). Both derived from registered count.
//  overflow: set has priority over ovf_clr in the same cycle.
//  m_ready while m_valid=0: ignored, no pointer movement.
//  Reset mid-frame or mid-read: contents discarded; the first rising rx_done after
//   release is captured normally.
// CONFIGURATION
//  Macro UART_RX_FIFO_TIMEOUT_EN:
//   defined   -> tick counter (AW-independent, clog2(TO_TICKS+1) bits) clears on push,
//                advances on tick while count!=0; reaching TO_TICKS sets rx_timeout
//                (level) and stops counting; rx_timeout clears on push or when count->0.
//                Lets the host drain partial messages without polling.
//   undefined -> no counter logic; rx_timeout driven constant 0; tick unused.
// STRUCTURE
//  Shared package uart_pkg: DBITS default, DEPTH default, AW derivation, TO_TICKS default.
//  One sub-module: uart_fifo_mem (DEPTH x DBITS, 1 sync write port, 1 async read port).
//  Pointer/count/flag control and optional timeout stay in uart_rx_fifo.
// TESTING
//  1 Reset, then rx_done pulse with 0xA5 -> next cycle m_valid=1, m_data=0xA5, count=1.
//  2 rx_done held high 10 cycles with 0x3C -> exactly one entry, count=1.
//  3 Push 16 bytes 0x00..0x0F, m_ready=0 -> full=1; push 0xFF -> overflow=1, count=16;
//    drain -> 0x00..0x0F in order, 0xFF never appears.
//  4 Full FIFO, push 0x77 with m_ready=1 same cycle -> count stays 16, overflow=0,
//    0x77 read last.
//  5 overflow=1, ovf_clr=1 with new overflowing push same cycle -> overflow stays 1;
//    ovf_clr alone next cycle -> overflow=0.
//  6 (TIMEOUT_EN, TO_TICKS=64) push 1 byte, 64 ticks, no push -> rx_timeout=1;
//    pop -> count=0, rx_timeout=0; assert rst low mid-sequence -> all outputs at reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared defaults for the UART receive-side FIFO slice.
package uart_pkg;
  localparam int DBITS    = 8;
  localparam int DEPTH    = 16;
  localparam int AW       = $clog2(DEPTH);
  localparam int TO_TICKS = 64;
endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int W  = DBITS,
  parameter int N  = DEPTH,
  parameter int AB = AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AB-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AB-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: edge-captured writes, FWFT valid/ready read.
// Optional line-silence timeout enabled by defining UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DBITS    = uart_pkg::DBITS,
  parameter int DEPTH    = uart_pkg::DEPTH,
  parameter int AW       = uart_pkg::AW,
  parameter int TO_TICKS = uart_pkg::TO_TICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             rx_done,
  input  logic [DBITS-1:0] rx_data,
  output logic             m_valid,
  output logic [DBITS-1:0] m_data,
  input  logic             m_ready,
  output logic [AW:0]      count,
  output logic             full,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             rx_timeout
);

  logic          rx_done_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, wr_en, ovf_set;

  assign m_valid = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign push    = rx_done & ~rx_done_q;
  assign pop     = m_valid & m_ready;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_done_q <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (pop && !wr_en) count <= count - 1'b1;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .W (DBITS),
    .N (DEPTH),
    .AB(AW)
  ) u_mem (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr),
    .wdata(rx_data),
    .raddr(rd_ptr),
    .rdata(m_data)
  );

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TO_TICKS + 1);
  logic [TW-1:0] to_cnt;
  logic          draining_to_empty;

  assign draining_to_empty = pop && !wr_en && (count == (AW+1)'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt     <= '0;
      rx_timeout <= 1'b0;
    end else if (push || draining_to_empty) begin
      to_cnt     <= '0;
      rx_timeout <= 1'b0;
    end else if (tick && m_valid && !rx_timeout) begin
      if (to_cnt == TW'(TO_TICKS - 1)) begin
        to_cnt     <= TW'(TO_TICKS);
        rx_timeout <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign rx_timeout  = 1'b0;
`endif

endmodule
